// File: rtl/circuit2_resp_analyzer.sv
// circuit2_resp_analyzer
// Compacts the circuit2 response stream into a serial-input signature register
// (SISR). In parallel it compares every sample against a per-pattern golden bit,
// counts mismatches and remembers the first failing pattern. Pass/fail is
// reported once N_PAT samples have been accepted.
//
// States
//   state  | meaning
//   IDLE   | after reset, waiting for start
//   RUN    | accepting z samples (z_valid=1), holding state otherwise
//   DONE   | N_PAT samples seen, results held until the next start
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   start      begin a run (sampled in IDLE or DONE)
//   z_valid    z carries the response of the current pattern
//   z          circuit2 output for the current pattern
//   busy       high in RUN
//   done       high in DONE
//   pass       in DONE: signature matches GOLDEN_SIG and no mismatches
//   signature  current SISR contents
//   mism_count number of samples that differed from EXP_RESP
//   fail_seen  at least one mismatch this run
//   first_fail pattern index of the first mismatch
module circuit2_resp_analyzer #(
  parameter int                   N_PAT      = 8,
  parameter int                   CW         = $clog2(N_PAT),
  parameter int                   SIG_W      = 8,
  parameter logic [SIG_W-1:0]     POLY       = 8'h1D,
  parameter logic [SIG_W-1:0]     SEED       = 8'h00,
  parameter logic [N_PAT-1:0]     EXP_RESP   = 8'h00,
  parameter logic [SIG_W-1:0]     GOLDEN_SIG = 8'h00
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             z_valid,
  input  logic             z,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [SIG_W-1:0] signature,
  output logic [CW:0]      mism_count,
  output logic             fail_seen,
  output logic [CW-1:0]    first_fail
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam logic [CW-1:0] LAST_PAT = CW'(N_PAT - 1);

  state_t           state_q;
  logic [SIG_W-1:0] sig_q, sig_d;
  logic [CW:0]      mism_q, mism_d;
  logic [CW-1:0]    pat_q;
  logic [CW-1:0]    ff_q;
  logic             fs_q;
  logic             busy_q, done_q, pass_q;
  logic             miss;

  // Next values for an accepted sample; only committed when z_valid in RUN.
  always_comb begin
    miss   = z ^ EXP_RESP[pat_q];
    sig_d  = {sig_q[SIG_W-2:0], 1'b0}
           ^ (sig_q[SIG_W-1] ? POLY : '0)
           ^ {{(SIG_W-1){1'b0}}, z};
    mism_d = mism_q + {{CW{1'b0}}, miss};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      sig_q   <= '0;
      mism_q  <= '0;
      pat_q   <= '0;
      ff_q    <= '0;
      fs_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_q <= S_RUN;
            sig_q   <= SEED;
            mism_q  <= '0;
            pat_q   <= '0;
            ff_q    <= '0;
            fs_q    <= 1'b0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
          end
        end
        S_RUN: begin
          if (z_valid) begin
            sig_q  <= sig_d;
            mism_q <= mism_d;
            if (miss && !fs_q) begin
              fs_q <= 1'b1;
              ff_q <= pat_q;
            end
            if (pat_q == LAST_PAT) begin
              state_q <= S_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              // Judge on the post-update values so pass is valid with done.
              pass_q  <= (sig_d == GOLDEN_SIG) && (mism_d == '0);
            end else begin
              pat_q <= pat_q + 1'b1;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign signature  = sig_q;
  assign mism_count = mism_q;
  assign fail_seen  = fs_q;
  assign first_fail = ff_q;

endmodule
